// File: rtl/scpad_pkg.sv
// Shared scratchpad write-path types: xbar descriptor and buffered write entry.
// Widths here set the defaults of the write request buffer.
package scpad_pkg;

    localparam int SCPAD_ADDR_WIDTH  = 12;
    localparam int SCPAD_WRBUF_DEPTH = 4;
    localparam int SCPAD_LINE_W      = 512;
    localparam int SCPAD_ID_W        = 8;

    typedef struct packed {
        logic [3:0] src_bank;
        logic [3:0] dst_bank;
        logic [7:0] shift;
    } xbar_desc_t;

    typedef struct packed {
        logic [SCPAD_ADDR_WIDTH-1:0] addr;
        logic [SCPAD_LINE_W-1:0]     data;
        xbar_desc_t                  xbar;
        logic [SCPAD_ID_W-1:0]       id;
    } sram_wr_entry_t;

endpackage

// File: rtl/sram_write_req_buffer_if.sv
// Bundles the latch-side, bank-side and retire signals of the write request buffer.
// Pure wiring; no state.
interface sram_write_req_buffer_if;
    import scpad_pkg::*;

    logic                        in_latched;
    logic [SCPAD_ADDR_WIDTH-1:0] in_addr;
    logic [SCPAD_LINE_W-1:0]     in_data;
    xbar_desc_t                  in_xbar;
    logic [SCPAD_ID_W-1:0]       in_id;
    logic                        be_stall;
    logic                        wr_valid;
    logic                        wr_ready;
    logic [SCPAD_ADDR_WIDTH-1:0] wr_addr;
    logic [SCPAD_LINE_W-1:0]     wr_data;
    xbar_desc_t                  wr_xbar;
    logic [SCPAD_ID_W-1:0]       wr_id;
    logic                        done_valid;
    logic [SCPAD_ID_W-1:0]       done_id;

    modport wrbuf (
        input  in_latched, in_addr, in_data, in_xbar, in_id, wr_ready,
        output be_stall, wr_valid, wr_addr, wr_data, wr_xbar, wr_id, done_valid, done_id
    );
    modport latch (
        output in_latched, in_addr, in_data, in_xbar, in_id,
        input  be_stall
    );
    modport bank (
        input  wr_valid, wr_addr, wr_data, wr_xbar, wr_id,
        output wr_ready
    );
    modport tracker (
        input  done_valid, done_id
    );

endinterface

// File: rtl/scpad_sync_fifo.sv
// Generic circular FIFO with separate occupancy count; head read combinationally.
// Latency: push visible at head the cycle after the write edge, no bypass.
// Backpressure: push while full is dropped unless a pop happens the same cycle.
module scpad_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_dat,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop & (count != '0);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push  = push & (~full | do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_write_req_buffer.sv
// Buffers assembled scratchpad write requests and drains them to the bank write port.
// Latency: push to wr_valid one cycle; retire pulse one cycle after the pop.
// Backpressure: be_stall at DEPTH-1 entries leaves one slot for the latch's registered reaction.
module sram_write_req_buffer
    import scpad_pkg::*;
#(
    parameter int DEPTH  = SCPAD_WRBUF_DEPTH,
    parameter int DATA_W = SCPAD_LINE_W,
    parameter int ADDR_W = SCPAD_ADDR_WIDTH,
    parameter int XBAR_W = $bits(xbar_desc_t),
    parameter int ID_W   = SCPAD_ID_W
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   in_latched,
    input  logic [ADDR_W-1:0]      in_addr,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [XBAR_W-1:0]      in_xbar,
    input  logic [ID_W-1:0]        in_id,
    output logic                   be_stall,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [DATA_W-1:0]      wr_data,
    output logic [XBAR_W-1:0]      wr_xbar,
    output logic [ID_W-1:0]        wr_id,
    output logic                   done_valid,
    output logic [ID_W-1:0]        done_id,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   overflow_err,
    input  logic                   err_clr
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int ENT_W = ADDR_W + DATA_W + XBAR_W + ID_W;

    logic [ENT_W-1:0] head_dat;
    logic [CW-1:0]    count;
    logic             pop;
    logic             full;

    scpad_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .nRST     (nRST),
        .push     (in_latched),
        .pop      (pop),
        .push_dat ({in_addr, in_data, in_xbar, in_id}),
        .head_dat (head_dat),
        .count    (count)
    );

    assign {wr_addr, wr_data, wr_xbar, wr_id} = head_dat;
    assign wr_valid  = (count != '0);
    assign pop       = wr_valid & wr_ready;
    assign full      = (count == CW'(DEPTH));
    assign be_stall  = (count >= CW'(DEPTH - 1));
    assign occupancy = count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            done_valid   <= 1'b0;
            done_id      <= '0;
            overflow_err <= 1'b0;
        end else begin
            done_valid <= pop;
            if (pop) done_id <= wr_id;
            // A dropped push wins over a same-cycle clear so no loss goes unreported.
            if (in_latched & full & ~pop) overflow_err <= 1'b1;
            else if (err_clr)             overflow_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_write_req_buffer.sv
// Randomized and directed stimulus against a queue-based model; monitor checks outputs each cycle.
module tb_sram_write_req_buffer;
    import scpad_pkg::*;

    localparam int DEPTH = SCPAD_WRBUF_DEPTH;

    logic                        CLK;
    logic                        nRST;
    logic                        in_latched;
    logic [SCPAD_ADDR_WIDTH-1:0] in_addr;
    logic [SCPAD_LINE_W-1:0]     in_data;
    logic [15:0]                 in_xbar;
    logic [7:0]                  in_id;
    logic                        be_stall;
    logic                        wr_valid;
    logic                        wr_ready;
    logic [SCPAD_ADDR_WIDTH-1:0] wr_addr;
    logic [SCPAD_LINE_W-1:0]     wr_data;
    logic [15:0]                 wr_xbar;
    logic [7:0]                  wr_id;
    logic                        done_valid;
    logic [7:0]                  done_id;
    logic [2:0]                  occupancy;
    logic                        overflow_err;
    logic                        err_clr;

    sram_write_req_buffer dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .in_latched   (in_latched),
        .in_addr      (in_addr),
        .in_data      (in_data),
        .in_xbar      (in_xbar),
        .in_id        (in_id),
        .be_stall     (be_stall),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_xbar      (wr_xbar),
        .wr_id        (wr_id),
        .done_valid   (done_valid),
        .done_id      (done_id),
        .occupancy    (occupancy),
        .overflow_err (overflow_err),
        .err_clr      (err_clr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [599:0] act, input logic [599:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a plain queue of accepted requests.
    sram_wr_entry_t ref_q[$];
    sram_wr_entry_t exp_q[$];
    logic [7:0]     done_q[$];
    bit             m_ovf;
    bit             m_done;
    bit             pop_m;
    bit             acc_m;
    sram_wr_entry_t ent;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ref_q.delete();
            exp_q.delete();
            done_q.delete();
            m_ovf  = 1'b0;
            m_done = 1'b0;
        end else begin
            pop_m  = (ref_q.size() != 0) && wr_ready;
            acc_m  = in_latched && ((ref_q.size() < DEPTH) || pop_m);
            m_done = pop_m;
            if (pop_m) begin
                ent = ref_q.pop_front();
                done_q.push_back(ent.id);
            end
            if (acc_m) begin
                ent.addr = in_addr;
                ent.data = in_data;
                ent.xbar = in_xbar;
                ent.id   = in_id;
                ref_q.push_back(ent);
                exp_q.push_back(ent);
            end
            if (in_latched && !acc_m) m_ovf = 1'b1;
            else if (err_clr)         m_ovf = 1'b0;
        end
    end

    sram_wr_entry_t got;
    sram_wr_entry_t want;

    always @(negedge CLK) begin
        if (nRST) begin
            check("wr_valid", wr_valid, ref_q.size() != 0);
            check("occupancy", occupancy, ref_q.size());
            check("be_stall", be_stall, ref_q.size() >= DEPTH - 1);
            check("overflow_err", overflow_err, m_ovf);
            check("done_valid", done_valid, m_done);
            if (done_valid) begin
                if (done_q.size() == 0) check("done_unexpected", 1, 0);
                else                    check("done_id", done_id, done_q.pop_front());
            end
            if (wr_valid && wr_ready) begin
                got.addr = wr_addr;
                got.data = wr_data;
                got.xbar = wr_xbar;
                got.id   = wr_id;
                if (exp_q.size() == 0) check("head_unexpected", 1, 0);
                else begin
                    want = exp_q.pop_front();
                    check("head_entry", got, want);
                end
            end
        end
    end

    function automatic logic [SCPAD_LINE_W-1:0] rand_line();
        logic [SCPAD_LINE_W-1:0] d;
        for (int i = 0; i < SCPAD_LINE_W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic drive(input logic l, input logic [7:0] id, input logic [11:0] addr,
                         input logic [SCPAD_LINE_W-1:0] d, input logic rdy, input logic clr);
        in_latched = l;
        in_id      = id;
        in_addr    = addr;
        in_data    = d;
        in_xbar    = 16'($urandom);
        wr_ready   = rdy;
        err_clr    = clr;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 12'h000, rand_line(), rdy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_valid"}, wr_valid, 0);
        check({tag, "_be_stall"}, be_stall, 0);
        check({tag, "_occupancy"}, occupancy, 0);
        check({tag, "_done_valid"}, done_valid, 0);
        check({tag, "_overflow_err"}, overflow_err, 0);
    endtask

    logic [SCPAD_LINE_W-1:0] a5_line;

    initial begin
        a5_line    = {(SCPAD_LINE_W/8){8'hA5}};
        nRST       = 1'b0;
        in_latched = 1'b0;
        in_id      = '0;
        in_addr    = '0;
        in_data    = '0;
        in_xbar    = '0;
        wr_ready   = 1'b0;
        err_clr    = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (3) @(posedge CLK);
        #1;
        nRST = 1'b1;

        // Single request.
        drive(1'b1, 8'h11, 12'h040, a5_line, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Fill to stall, overflow, clear, push with pop at full, drain.
        for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 12'(i * 16), rand_line(), 1'b0, 1'b0);
        drive(1'b1, 8'h05, 12'h050, rand_line(), 1'b0, 1'b0);
        idle(1, 1'b0);
        drive(1'b0, 8'h00, 12'h000, rand_line(), 1'b0, 1'b1);
        drive(1'b1, 8'h06, 12'h060, rand_line(), 1'b1, 1'b0);
        idle(6, 1'b1);

        // Pointer wrap with alternating ready.
        for (int i = 0; i < 10; i++) drive(1'b1, 8'(8'h20 + i), 12'(i), rand_line(), i[0] == 1'b0, 1'b0);
        idle(8, 1'b1);

        // Reset mid-operation with overflow_err set and 3 entries held.
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h30 + i), 12'(i), rand_line(), 1'b0, 1'b0);
        drive(1'b0, 8'h00, 12'h000, rand_line(), 1'b1, 1'b0);
        wr_ready = 1'b0;
        nRST     = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        drive(1'b1, 8'h7E, 12'h123, rand_line(), 1'b1, 1'b0);
        idle(3, 1'b1);

        // Random traffic.
        for (int i = 0; i < 2000; i++)
            drive($urandom_range(0, 9) < 6, 8'($urandom), 12'($urandom), rand_line(),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
        idle(8, 1'b1);

        check("exp_q_empty", exp_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_write_req_buffer.md
Name: sram_write_req_buffer

Overview:
- Sits directly downstream of the SRAM write latch.
- Captures each fully assembled scratchpad write request (512-bit line, scratchpad address, xbar descriptor, DRAM id) when the latch pulses its latched strobe.
- Buffers requests in a small FIFO and drains them to the scratchpad bank write port over a valid/ready handshake.
- Returns backpressure (be_stall) to the latch and a registered retire pulse carrying the DRAM id to the DRAM request tracker.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- DATA_W, 512, write line width (32 elements x 16 bits).
- ADDR_W, SCPAD_ADDR_WIDTH, scratchpad address width.
- XBAR_W, $bits(xbar_desc_t), packed xbar descriptor width.
- ID_W, 8, DRAM transaction id width.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- in_latched  in  1  push strobe (sram_write_req_latched from latch)
- in_addr  in  ADDR_W  write address
- in_data  in  DATA_W  write line
- in_xbar  in  XBAR_W  xbar descriptor
- in_id  in  ID_W  DRAM id of request
- be_stall  out  1  backpressure to latch
- wr_valid  out  1  head request valid to bank port
- wr_ready  in  1  bank port accepts head
- wr_addr  out  ADDR_W  head address
- wr_data  out  DATA_W  head line
- wr_xbar  out  XBAR_W  head descriptor
- wr_id  out  ID_W  head id
- done_valid  out  1  retire pulse
- done_id  out  ID_W  id of retired request
- occupancy  out  $clog2(DEPTH)+1  entries held
- overflow_err  out  1  sticky: push dropped while full
- err_clr  in  1  clears overflow_err

Behaviour:
- Reset is asynchronous on nRST low. Pointers, count, done_valid, done_id and overflow_err all clear to 0. Storage is not reset.
- After reset: wr_valid=0, be_stall=0, occupancy=0. wr_addr/wr_data/wr_xbar/wr_id are don't-care while wr_valid=0.
- Storage: circular array with rd_ptr/wr_ptr of $clog2(DEPTH) bits; both wrap modulo DEPTH. count is held separately, range 0..DEPTH.
- push = in_latched. pop = wr_valid & wr_ready.
- wr_valid = (count != 0). Head fields are read combinationally from mem[rd_ptr].
- Push-to-output latency: a push into an empty FIFO at edge N gives wr_valid=1 in cycle N+1. There is no same-cycle bypass.
- be_stall = (count >= DEPTH-1), decoded from registered count. One slot of slack covers the latch's registered reaction.
- Push when count<DEPTH: write mem[wr_ptr], then increment wr_ptr.
- Push when count==DEPTH:
  - With a simultaneous pop: the push is accepted and count stays at DEPTH.
  - Without a pop: data is dropped, pointers and count are unchanged, and overflow_err is set.
- Pop: increment rd_ptr.
- Count update: +1 on push-only, -1 on pop-only, unchanged on both or neither.
- Pop when empty is impossible, because wr_valid=0.
- Handshake rules:
  - Once wr_valid=1, the head stays stable until popped.
  - wr_ready may toggle freely. The bank port must not depend on wr_valid combinationally in a loop.
- Retire: on each pop, done_valid=1 and done_id=wr_id are registered for the next cycle. Otherwise done_valid=0. Back-to-back pops give back-to-back done pulses.
- overflow_err: the set condition has priority over err_clr in the same cycle.
- occupancy = count.
- Reset mid-operation (nRST asserted in any state) empties the FIFO immediately. Outputs drop combinationally-with-reset to the reset values above.

Decomposition:
- scpad_pkg holds:
  - sram_wr_entry_t: packed struct {addr, data, xbar_desc_t xbar, id}.
  - SCPAD_WRBUF_DEPTH = 4.
  - SCPAD_LINE_W = 512.
- Matching interface sram_write_req_buffer_if.vh, with modports for the buffer, the latch side and the bank side.
- Natural sub-module: scpad_sync_fifo (generic parameterised storage with push/pop/count). The top adds stall decode, overflow flag and retire register.

Test Plan:
- Single request: reset, push id=0x11, addr=0x040, data=all 0xA5, with wr_ready=1 → wr_valid high one cycle after push with matching fields; done_valid=1, done_id=0x11 the cycle after the pop; occupancy returns to 0.
- Fill to stall: DEPTH=4, wr_ready=0, push ids 1..3 → be_stall asserts at count=3. Push id 4 → occupancy=4, overflow_err=0. Then drain with wr_ready=1 → ids retire in order 1,2,3,4, one per cycle.
- Overflow: with count=4 and wr_ready=0, push id 5 → overflow_err=1, occupancy stays 4, id 5 never appears. Pulse err_clr → overflow_err=0.
- Simultaneous push/pop at full: count=4, wr_ready=1, push id 6 in the same cycle → overflow_err=0, count stays 4, id 6 retires last.
- Pointer wrap: stream 10 requests (ids 0x20..0x29) with wr_ready alternating 1/0 → every id retires exactly once in order; occupancy never exceeds 4.
- Reset mid-operation: with 3 entries held, pulse nRST low for 1 cycle → wr_valid=0, be_stall=0, occupancy=0, done_valid=0, overflow_err=0 immediately. A new push afterwards retires correctly.
